// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timebase counter.
// Digits are BCD nibbles ordered c_ones (index 0) up to m_tens (index 5).
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 6;
  localparam int TIME_W     = DIGIT_W * NUM_DIGITS;
  localparam int S_TENS_IDX = 3;

  localparam logic [DIGIT_W-1:0] DEC_LIMIT = 4'd9;
  localparam logic [DIGIT_W-1:0] SEX_LIMIT = 4'd5;

  // Two-digit BCD encoding of a binary value in 0..99.
  function automatic logic [2*DIGIT_W-1:0] to_bcd2(input int value);
    to_bcd2 = {DIGIT_W'(value / 10), DIGIT_W'(value % 10)};
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit of the elapsed-time cascade: counts 0..limit on inc and
// flags carry_out in the cycle it wraps back to zero.
module bcd_digit_counter
  import stopwatch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               inc,
  input  logic [DIGIT_W-1:0] limit,
  output logic               carry_out,
  output logic [DIGIT_W-1:0] digit
);

  logic [DIGIT_W-1:0] r_digit;
  logic               w_at_limit;

  // >= rather than == so a digit can never get stuck above its limit
  assign w_at_limit = (r_digit >= limit);
  assign carry_out  = inc & w_at_limit;
  assign digit      = r_digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (inc) begin
      r_digit <= w_at_limit ? '0 : r_digit + 1'b1;
    end
  end

endmodule

// File: rtl/stopwatch_timebase_counter.sv
// Turns the asynchronous 100 Hz timebase into centisecond ticks and keeps
// MM:SS.CC elapsed time with run/pause, lap freeze and clear control.
module stopwatch_timebase_counter
  import stopwatch_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_MINUTES = 59
) (
  input  logic              clk_50MHz,
  input  logic              rst_n,
  input  logic              clk_100Hz_in,
  input  logic              start_stop_req,
  input  logic              lap_req,
  input  logic              clear_req,
  output logic [TIME_W-1:0] time_bcd,
  output logic              running,
  output logic              lap_active,
  output logic              tick_100Hz,
  output logic              rollover
);

  localparam logic [2*DIGIT_W-1:0] MAX_MIN_BCD = to_bcd2(MAX_MINUTES);
  localparam logic [TIME_W-1:0]    MAX_COUNT   =
    {MAX_MIN_BCD, SEX_LIMIT, DEC_LIMIT, DEC_LIMIT, DEC_LIMIT};

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_tick;

  state_t r_state;
  state_t w_state_next;
  logic   r_lap_active;
  logic   w_lap_active_next;
  logic   w_lap_capture;
  logic   w_clear_cmd;

  logic [NUM_DIGITS:0]                 w_inc;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  w_digit;
  logic [NUM_DIGITS-1:0][DIGIT_W-1:0]  w_digit_next;
  logic                                w_count_en;
  logic                                w_at_max;
  logic                                w_wrap;
  logic                                w_clr_count;

  logic [TIME_W-1:0] r_lap;
  logic [TIME_W-1:0] w_lap_next;
  logic [TIME_W-1:0] r_time_bcd;
  logic              r_running;
  logic              r_rollover;

  // The 100 Hz input is plain asynchronous data here, never a clock
  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], clk_100Hz_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_tick     = r_sync[SYNC_STAGES-1] & ~r_hist;
  assign tick_100Hz = w_tick;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_lap_active <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lap_active <= w_lap_active_next;
    end
  end

  // clear beats start/stop beats lap; losing requests are simply dropped
  always_comb begin
    w_state_next      = r_state;
    w_lap_active_next = r_lap_active;
    w_lap_capture     = 1'b0;
    w_clear_cmd       = 1'b0;
    if (clear_req) begin
      if (r_state != RUN) begin
        w_state_next      = IDLE;
        w_lap_active_next = 1'b0;
        w_clear_cmd       = 1'b1;
      end
    end else if (start_stop_req) begin
      case (r_state)
        IDLE:    w_state_next = RUN;
        RUN:     w_state_next = PAUSE;
        PAUSE:   w_state_next = RUN;
        default: w_state_next = IDLE;
      endcase
    end else if (lap_req) begin
      if (r_state == RUN) begin
        w_lap_active_next = ~r_lap_active;
        w_lap_capture     = ~r_lap_active;
      end else if (r_state == PAUSE) begin
        w_lap_active_next = 1'b0;
      end
    end
  end

  // Counting is gated by the state before any transition in this cycle
  assign w_count_en = (r_state == RUN) & w_tick;
  assign w_inc[0]   = w_count_en;
  assign w_at_max   = (w_digit == MAX_COUNT);
  // The m_tens carry only fires at 99:59.99, which is the wrap point when MAX_MINUTES is 99
  assign w_wrap      = (w_count_en & w_at_max) | w_inc[NUM_DIGITS];
  assign w_clr_count = w_clear_cmd | w_wrap;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      localparam logic [DIGIT_W-1:0] LIMIT = (gi == S_TENS_IDX) ? SEX_LIMIT : DEC_LIMIT;

      bcd_digit_counter u_digit (
        .clk       (clk_50MHz),
        .rst_n     (rst_n),
        .clr       (w_clr_count),
        .inc       (w_inc[gi]),
        .limit     (LIMIT),
        .carry_out (w_inc[gi+1]),
        .digit     (w_digit[gi])
      );

      // Mirror of the digit's next value so lap capture and display see the post-tick count
      assign w_digit_next[gi] = w_clr_count  ? '0 :
                                w_inc[gi+1]  ? '0 :
                                w_inc[gi]    ? w_digit[gi] + 1'b1 :
                                               w_digit[gi];
    end
  endgenerate

  assign w_lap_next = w_lap_capture ? w_digit_next : r_lap;

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_lap      <= '0;
      r_time_bcd <= '0;
      r_running  <= 1'b0;
      r_rollover <= 1'b0;
    end else begin
      r_lap      <= w_lap_next;
      r_time_bcd <= w_lap_active_next ? w_lap_next : w_digit_next;
      r_running  <= (w_state_next == RUN);
      r_rollover <= w_wrap;
    end
  end

  assign time_bcd   = r_time_bcd;
  assign running    = r_running;
  assign lap_active = r_lap_active;
  assign rollover   = r_rollover;

endmodule

// File: doc/stopwatch_timebase_counter.md
Name: stopwatch_timebase_counter

Overview:
Receiving end of the divided 100 Hz timebase. Samples the toggling clk_100Hz as data in the clk_50MHz domain and edge-detects it into single-cycle centisecond ticks. Accumulates elapsed time as six BCD digits (MM:SS.CC) under start/stop, lap and clear control. Output feeds the 7-segment scan logic, which is clocked by clk_display.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on clk_100Hz_in (legal 2..4)
MAX_MINUTES, 59, highest minute value before wrap (legal 1..99)

Ports:
clk_50MHz  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous, active-low reset
clk_100Hz_in  input  1  divided 100 Hz square wave, treated as asynchronous data
start_stop_req  input  1  debounced single-cycle pulse, toggles run/pause
lap_req  input  1  debounced single-cycle pulse, toggles lap freeze
clear_req  input  1  debounced single-cycle pulse, zeroes time when not running
time_bcd  output  24  displayed time {m_tens,m_ones,s_tens,s_ones,c_tens,c_ones}, 4 bits each
running  output  1  high in RUN state
lap_active  output  1  high while display is frozen on a lap capture
tick_100Hz  output  1  one-cycle pulse per detected rising edge of clk_100Hz_in
rollover  output  1  one-cycle pulse when count wraps MAX_MINUTES:59.99 -> 00:00.00

Behaviour:
- Reset (async assert, sync release in effect via flops): state IDLE; count, lap register, time_bcd = 0; running, lap_active, tick_100Hz, rollover = 0; synchroniser and edge-history flops = 0.
- Tick path: SYNC_STAGES flops, then a history flop; tick_100Hz = sync_out & ~hist. First clk_50MHz edge sampling clk_100Hz_in high -> tick_100Hz asserts SYNC_STAGES edges later, for exactly 1 cycle. Exactly one tick per input rising edge; falling edges produce nothing.
- FSM states: IDLE, RUN, PAUSE (encoding in package).
  - IDLE + start_stop_req -> RUN
  - RUN + start_stop_req -> PAUSE
  - PAUSE + start_stop_req -> RUN
  - PAUSE + clear_req -> IDLE: count = 0, lap_active = 0
  - IDLE + clear_req -> stays IDLE: count = 0
  - RUN + clear_req -> ignored
- Priority in the same cycle: clear_req > start_stop_req > lap_req. Lower-priority requests in that cycle are dropped, not queued.
- Counting: count increments only when the current (pre-transition) state is RUN and tick_100Hz = 1.
  - Tick in the same cycle as the RUN->PAUSE request is counted.
  - Tick in the same cycle as the IDLE/PAUSE->RUN request is not counted.
- Arithmetic is a BCD cascade:
  - c_ones 0..9, carries into c_tens 0..9
  - carries into s_ones 0..9, then s_tens 0..5
  - carries into minutes 00..MAX_MINUTES (two BCD digits)
  - At MAX_MINUTES:59.99 a tick gives 00:00.00 and a 1-cycle rollover pulse in the same cycle as the wrap; counting continues.
  - No digit ever holds a value > 9 (or > 5 for s_tens).
- Lap:
  - RUN + lap_req with lap_active = 0: capture the post-update count into the lap register and set lap_active = 1.
  - RUN + lap_req with lap_active = 1: clear lap_active (display resumes live count).
  - PAUSE + lap_req: only clears lap_active; never captures.
  - IDLE: lap_req ignored.
- Output: time_bcd is registered, = lap_active ? lap register : count. Latency is 1 cycle after the tick or count update; tick-to-display is 1 cycle.
- running is a registered decode of state == RUN.
- Reset asserted mid-count forces the reset values immediately, regardless of state or pending pulses.

Decomposition:
- Package stopwatch_pkg:
  - state enum {IDLE, RUN, PAUSE}
  - BCD digit width (4)
  - digit limits (9, 5)
  - time vector width (24)
- Sub-module bcd_digit_counter (ports: clk, rst_n, clr, inc, limit, carry_out, digit), instantiated six times in a carry chain. Minute-pair wrap at MAX_MINUTES is handled in the top level.
- Synchroniser and edge detect stay inline.

Test Plan:
- Reset then 120 input periods in IDLE -> 120 tick_100Hz pulses, time_bcd stays 0x000000, running = 0.
- start_stop_req, 150 ticks, start_stop_req -> time_bcd = 0x000150 (00:01.50), running = 0. Further ticks do not change it.
- Preload via ticks to 00:59.99, 1 tick -> 0x010000. With MAX_MINUTES = 59, from 59:59.99, 1 tick -> 0x000000 and a single-cycle rollover.
- RUN at 00:02.00, lap_req, 37 ticks -> time_bcd holds 0x000200, lap_active = 1; lap_req -> time_bcd = 0x000237.
- clear_req and start_stop_req in the same cycle while PAUSE at 0x000500 -> state IDLE, time_bcd = 0x000000. clear_req while RUN -> ignored and counting continues.
- start_stop_req coincident with tick from RUN at 0x000010 -> count 0x000011, then PAUSE. Assert rst_n low mid-count -> all outputs 0 before the next clk edge.
